// File: rtl/smc_lite16_pkg.sv
// Shared encodings, FSM states and beat arithmetic for the SMC lite sequencer.
package smc_lite16_pkg;

    localparam logic [1:0] XSIZ_8   = 2'b00;
    localparam logic [1:0] XSIZ_16  = 2'b01;
    localparam logic [1:0] XSIZ_32  = 2'b10;
    localparam logic [1:0] BSIZ_8   = 2'b00;
    localparam logic [1:0] BSIZ_16  = 2'b01;
    localparam logic [1:0] BSIZ_32  = 2'b10;
    localparam logic [1:0] SIZE_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } smc_state_e;

    // Number of external beats: 1, 2 or 4.
    function automatic logic [2:0] num_beats(input logic [1:0] xfer, input logic [1:0] bus);
        if (xfer > bus) return 3'b001 << (xfer - bus);
        else            return 3'b001;
    endfunction

    // Low two EMI address bits for beat k of a transfer.
    function automatic logic [1:0] addr_lo(input logic [1:0] xfer, input logic [1:0] bus,
                                           input logic big_endian, input logic [1:0] a,
                                           input logic [1:0] k);
        logic [1:0] base;
        logic [1:0] kk;
        logic [1:0] off;
        if (xfer == XSIZ_8) return a;
        base = (xfer == XSIZ_16) ? {a[1], 1'b0} : 2'b00;
        // Little-endian walks down from the top chunk, big-endian walks up.
        kk   = big_endian ? k : 2'(num_beats(xfer, bus) - 3'd1) - k;
        off  = (bus == BSIZ_16) ? {kk[0], 1'b0} : kk;
        return base + off;
    endfunction

endpackage

// File: rtl/smc_be_dec16.sv
// Combinational byte-lane decoder: active-low byte enables for one beat.
module smc_be_dec16
    import smc_lite16_pkg::*;
(
    input  logic [1:0] xfer,
    input  logic [1:0] bus,
    input  logic       big_endian,
    input  logic [1:0] addr,
    output logic [3:0] n_be
);

    logic [1:0] lane;

    // Select the active lanes from bus width, transfer size and endianness.
    always_comb begin
        n_be = 4'hF;
        lane = 2'd0;
        case (bus)
            BSIZ_8: n_be = 4'b1110;
            BSIZ_16: begin
                if (xfer == XSIZ_8) begin
                    lane = {1'b0, addr[0] ^ big_endian};
                    n_be = ~(4'b0001 << lane);
                end else begin
                    n_be = 4'b1100;
                end
            end
            BSIZ_32: begin
                case (xfer)
                    XSIZ_8: begin
                        lane = big_endian ? (2'd3 - addr) : addr;
                        n_be = ~(4'b0001 << lane);
                    end
                    XSIZ_16: n_be = (addr[1] ^ big_endian) ? 4'b0011 : 4'b1100;
                    XSIZ_32: n_be = 4'b0000;
                    default: n_be = 4'hF;
                endcase
            end
            default: n_be = 4'hF;
        endcase
    end

endmodule

// File: rtl/smc_addr_seq16.sv
// Address / chip-select / byte-enable sequencer for one AHB transfer,
// counting external beats reported by the timing FSM.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high exactly while the sequencer is idle, and req_valid need not
// wait for req_ready.
module smc_addr_seq16
    import smc_lite16_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_CS   = 8,
    parameter int TURN_CYC = 0
) (
    input  logic              sys_clk16,
    input  logic              n_sys_reset16,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [NUM_CS-1:0] req_cs,
    input  logic [1:0]        req_xfer_size,
    input  logic [1:0]        req_bus_size,
    input  logic              req_big_endian,
    input  logic              beat_done,
    input  logic              abort,
    output logic [ADDR_W-1:0] smc_addr,
    output logic [NUM_CS-1:0] smc_n_cs,
    output logic [3:0]        smc_n_be,
    output logic [1:0]        beat_idx,
    output logic              last_beat,
    output logic              busy,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] TURN_LAST = 2'(TURN_CYC - 1);
    localparam bit         HAS_TURN  = (TURN_CYC > 0);

    smc_state_e        state, state_nx;
    logic [1:0]        k, k_nx, last_idx, last_idx_nx, tcnt, tcnt_nx;
    logic [1:0]        cap_xfer, cap_xfer_nx, cap_bus, cap_bus_nx, cap_a, cap_a_nx;
    logic              cap_be, cap_be_nx;
    logic [NUM_CS-1:0] cap_cs, cap_cs_nx, n_cs_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [3:0]        n_be_dec, n_be_nx;
    logic              done_nx, err_nx, last_nx, req_ok;

    assign req_ok = (req_xfer_size != SIZE_BAD) && (req_bus_size != SIZE_BAD) &&
                    (req_cs != '0) && ((req_cs & (req_cs - NUM_CS'(1))) == '0);

    // Next state, beat counter, captured request and registered output values.
    always_comb begin
        state_nx    = state;
        k_nx        = k;
        last_idx_nx = last_idx;
        tcnt_nx     = tcnt;
        cap_xfer_nx = cap_xfer;
        cap_bus_nx  = cap_bus;
        cap_a_nx    = cap_a;
        cap_be_nx   = cap_be;
        cap_cs_nx   = cap_cs;
        addr_nx     = smc_addr;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            k_nx     = 2'd0;
            tcnt_nx  = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !req_ok) begin
                        err_nx = 1'b1;
                    end else if (req_valid) begin
                        state_nx    = ACCESS;
                        k_nx        = 2'd0;
                        cap_xfer_nx = req_xfer_size;
                        cap_bus_nx  = req_bus_size;
                        cap_a_nx    = req_addr[1:0];
                        cap_be_nx   = req_big_endian;
                        cap_cs_nx   = req_cs;
                        last_idx_nx = 2'(num_beats(req_xfer_size, req_bus_size) - 3'd1);
                        addr_nx     = {req_addr[ADDR_W-1:2],
                                       addr_lo(req_xfer_size, req_bus_size, req_big_endian,
                                               req_addr[1:0], 2'd0)};
                    end
                end
                ACCESS: begin
                    if (beat_done && (k == last_idx)) begin
                        state_nx = IDLE;
                        k_nx     = 2'd0;
                        done_nx  = 1'b1;
                    end else if (beat_done) begin
                        k_nx     = k + 2'd1;
                        tcnt_nx  = 2'd0;
                        state_nx = HAS_TURN ? TURN : ACCESS;
                        addr_nx  = {smc_addr[ADDR_W-1:2],
                                    addr_lo(cap_xfer, cap_bus, cap_be, cap_a, k + 2'd1)};
                    end
                end
                TURN: begin
                    if (tcnt == TURN_LAST) state_nx = ACCESS;
                    else                   tcnt_nx  = tcnt + 2'd1;
                end
                default: state_nx = IDLE;
            endcase
        end
        n_cs_nx = (state_nx == ACCESS) ? ~cap_cs_nx : '1;
        n_be_nx = (state_nx == ACCESS) ? n_be_dec : 4'hF;
        last_nx = (state_nx != IDLE) && (k_nx == last_idx_nx);
    end

    smc_be_dec16 u_be_dec (
        .xfer       (cap_xfer_nx),
        .bus        (cap_bus_nx),
        .big_endian (cap_be_nx),
        .addr       (cap_a_nx),
        .n_be       (n_be_dec)
    );

    // State, captured request and registered EMI outputs.
    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            state     <= IDLE;
            k         <= 2'd0;
            last_idx  <= 2'd0;
            tcnt      <= 2'd0;
            cap_xfer  <= 2'd0;
            cap_bus   <= 2'd0;
            cap_a     <= 2'd0;
            cap_be    <= 1'b0;
            cap_cs    <= '0;
            smc_addr  <= '0;
            smc_n_cs  <= '1;
            smc_n_be  <= 4'hF;
            last_beat <= 1'b0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            k         <= k_nx;
            last_idx  <= last_idx_nx;
            tcnt      <= tcnt_nx;
            cap_xfer  <= cap_xfer_nx;
            cap_bus   <= cap_bus_nx;
            cap_a     <= cap_a_nx;
            cap_be    <= cap_be_nx;
            cap_cs    <= cap_cs_nx;
            smc_addr  <= addr_nx;
            smc_n_cs  <= n_cs_nx;
            smc_n_be  <= n_be_nx;
            last_beat <= last_nx;
            xfer_done <= done_nx;
            xfer_err  <= err_nx;
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign beat_idx  = k;
    assign dbg_state = state;

endmodule

// File: tb/tb_smc_addr_seq16.sv
// Bench for smc_addr_seq16: two instances (no turnaround / two-cycle turnaround)
// checked against a byte-level reference model of each transfer.
module tb_smc_addr_seq16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        beat_done [2];
    logic        abort_i   [2];
    logic [31:0] req_addr;
    logic [7:0]  req_cs;
    logic [1:0]  xs, bs;
    logic        be;

    logic        o_ready [2];
    logic [31:0] o_addr  [2];
    logic [7:0]  o_ncs   [2];
    logic [3:0]  o_nbe   [2];
    logic [1:0]  o_bidx  [2];
    logic        o_last  [2];
    logic        o_busy  [2];
    logic        o_done  [2];
    logic        o_err   [2];
    logic [1:0]  o_dbg   [2];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  exp_be_q[$];
    logic [31:0] last_addr [2];

    // clock / reset block
    always #5 clk = ~clk;

    smc_addr_seq16 #(.ADDR_W(32), .NUM_CS(8), .TURN_CYC(0)) u_dut0 (
        .sys_clk16(clk), .n_sys_reset16(rst_n), .req_valid(req_valid[0]), .req_ready(o_ready[0]),
        .req_addr(req_addr), .req_cs(req_cs), .req_xfer_size(xs), .req_bus_size(bs),
        .req_big_endian(be), .beat_done(beat_done[0]), .abort(abort_i[0]),
        .smc_addr(o_addr[0]), .smc_n_cs(o_ncs[0]), .smc_n_be(o_nbe[0]), .beat_idx(o_bidx[0]),
        .last_beat(o_last[0]), .busy(o_busy[0]), .xfer_done(o_done[0]), .xfer_err(o_err[0]),
        .dbg_state(o_dbg[0]));

    smc_addr_seq16 #(.ADDR_W(32), .NUM_CS(8), .TURN_CYC(2)) u_dut1 (
        .sys_clk16(clk), .n_sys_reset16(rst_n), .req_valid(req_valid[1]), .req_ready(o_ready[1]),
        .req_addr(req_addr), .req_cs(req_cs), .req_xfer_size(xs), .req_bus_size(bs),
        .req_big_endian(be), .beat_done(beat_done[1]), .abort(abort_i[1]),
        .smc_addr(o_addr[1]), .smc_n_cs(o_ncs[1]), .smc_n_be(o_nbe[1]), .beat_idx(o_bidx[1]),
        .last_beat(o_last[1]), .busy(o_busy[1]), .xfer_done(o_done[1]), .xfer_err(o_err[1]),
        .dbg_state(o_dbg[1]));

    // Reference model: split the naturally aligned transfer region into bus-sized
    // chunks, order them by endianness and mark which byte lanes each chunk uses.
    task automatic model(input logic [31:0] a, input logic [1:0] x, input logic [1:0] b,
                         input logic e);
        int xb, bb, ch, n, j, lane, byte_lo;
        logic [31:0] start, ba;
        logic [3:0]  m;
        xb    = 1 << x;
        bb    = 1 << b;
        ch    = (xb < bb) ? xb : bb;
        n     = (xb > bb) ? (xb / bb) : 1;
        start = a & ~(32'(xb - 1));
        for (int k = 0; k < n; k++) begin
            j  = e ? k : (n - 1 - k);
            ba = start + 32'(j * ch);
            m  = 4'h0;
            for (int i = 0; i < ch; i++) begin
                byte_lo = int'(ba[1:0]) + i;
                lane    = e ? (bb - 1 - (byte_lo % bb)) : (byte_lo % bb);
                m[lane] = 1'b1;
            end
            exp_q.push_back(ba);
            exp_be_q.push_back(~m);
        end
    endtask

    // Driver + checker for one complete transfer; entered and left at a negedge.
    // hold = cycles per beat before beat_done (0 = random 1..3).
    task automatic run_xfer(input int sel, input logic [31:0] a, input logic [7:0] cs,
                            input logic [1:0] x, input logic [1:0] b, input logic e,
                            input int hold);
        int n, h, tc;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic        el;
        model(a, x, b, e);
        n  = exp_q.size();
        tc = (sel == 1) ? 2 : 0;
        checks++;
        if (o_ready[sel] !== 1'b1) begin errors++; $display("FAIL ready_before_req sel=%0d got=%b exp=1", sel, o_ready[sel]); end
        req_addr = a; req_cs = cs; xs = x; bs = b; be = e; req_valid[sel] = 1'b1;
        @(negedge clk);
        req_valid[sel] = 1'b0;
        req_addr = $urandom; req_cs = 8'($urandom); xs = 2'($urandom); bs = 2'($urandom); be = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            ea = exp_q.pop_front();
            eb = exp_be_q.pop_front();
            el = (k == n - 1);
            h  = (hold > 0) ? hold : int'($urandom_range(1, 3));
            if (k > 0 && tc > 0) begin
                for (int t = 0; t < tc; t++) begin
                    checks += 4;
                    if (o_addr[sel] !== ea)   begin errors++; $display("FAIL gap_addr sel=%0d k=%0d got=%h exp=%h", sel, k, o_addr[sel], ea); end
                    if (o_ncs[sel] !== 8'hFF) begin errors++; $display("FAIL gap_ncs sel=%0d k=%0d got=%b exp=11111111", sel, k, o_ncs[sel]); end
                    if (o_nbe[sel] !== 4'hF)  begin errors++; $display("FAIL gap_nbe sel=%0d k=%0d got=%b exp=1111", sel, k, o_nbe[sel]); end
                    if (o_busy[sel] !== 1'b1) begin errors++; $display("FAIL gap_busy sel=%0d k=%0d got=%b exp=1", sel, k, o_busy[sel]); end
                    beat_done[sel] = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                beat_done[sel] = 1'b0;
            end
            for (int c = 0; c < h; c++) begin
                checks += 7;
                if (o_addr[sel] !== ea)    begin errors++; $display("FAIL beat_addr sel=%0d k=%0d got=%h exp=%h", sel, k, o_addr[sel], ea); end
                if (o_ncs[sel] !== ~cs)    begin errors++; $display("FAIL beat_ncs sel=%0d k=%0d got=%b exp=%b", sel, k, o_ncs[sel], ~cs); end
                if (o_nbe[sel] !== eb)     begin errors++; $display("FAIL beat_nbe sel=%0d k=%0d got=%b exp=%b", sel, k, o_nbe[sel], eb); end
                if (o_bidx[sel] !== 2'(k)) begin errors++; $display("FAIL beat_idx sel=%0d got=%0d exp=%0d", sel, o_bidx[sel], k); end
                if (o_last[sel] !== el)    begin errors++; $display("FAIL last_beat sel=%0d k=%0d got=%b exp=%b", sel, k, o_last[sel], el); end
                if (o_busy[sel] !== 1'b1)  begin errors++; $display("FAIL beat_busy sel=%0d k=%0d got=%b exp=1", sel, k, o_busy[sel]); end
                if (o_done[sel] !== 1'b0)  begin errors++; $display("FAIL early_done sel=%0d k=%0d got=%b exp=0", sel, k, o_done[sel]); end
                beat_done[sel] = (c == h - 1);
                @(negedge clk);
            end
            beat_done[sel] = 1'b0;
        end
        last_addr[sel] = ea;
        checks += 5;
        if (o_done[sel] !== 1'b1)   begin errors++; $display("FAIL xfer_done sel=%0d got=%b exp=1", sel, o_done[sel]); end
        if (o_busy[sel] !== 1'b0)   begin errors++; $display("FAIL end_busy sel=%0d got=%b exp=0", sel, o_busy[sel]); end
        if (o_ncs[sel] !== 8'hFF)   begin errors++; $display("FAIL end_ncs sel=%0d got=%b exp=11111111", sel, o_ncs[sel]); end
        if (o_nbe[sel] !== 4'hF)    begin errors++; $display("FAIL end_nbe sel=%0d got=%b exp=1111", sel, o_nbe[sel]); end
        if (o_addr[sel] !== ea)     begin errors++; $display("FAIL end_addr_hold sel=%0d got=%h exp=%h", sel, o_addr[sel], ea); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks += 9;
            if (o_addr[s] !== 32'h0) begin errors++; $display("FAIL rst_addr sel=%0d got=%h exp=0", s, o_addr[s]); end
            if (o_ncs[s] !== 8'hFF)  begin errors++; $display("FAIL rst_ncs sel=%0d got=%b exp=11111111", s, o_ncs[s]); end
            if (o_nbe[s] !== 4'hF)   begin errors++; $display("FAIL rst_nbe sel=%0d got=%b exp=1111", s, o_nbe[s]); end
            if (o_bidx[s] !== 2'd0)  begin errors++; $display("FAIL rst_bidx sel=%0d got=%0d exp=0", s, o_bidx[s]); end
            if (o_last[s] !== 1'b0)  begin errors++; $display("FAIL rst_last sel=%0d got=%b exp=0", s, o_last[s]); end
            if (o_busy[s] !== 1'b0)  begin errors++; $display("FAIL rst_busy sel=%0d got=%b exp=0", s, o_busy[s]); end
            if (o_done[s] !== 1'b0)  begin errors++; $display("FAIL rst_done sel=%0d got=%b exp=0", s, o_done[s]); end
            if (o_err[s] !== 1'b0)   begin errors++; $display("FAIL rst_err sel=%0d got=%b exp=0", s, o_err[s]); end
            if (o_ready[s] !== 1'b1) begin errors++; $display("FAIL rst_ready sel=%0d got=%b exp=1", s, o_ready[s]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plan_directed();
        run_xfer(0, 32'h0000_0100, 8'h01, 2'b10, 2'b00, 1'b0, 2);  // xfer32/bus8 LE
        run_xfer(1, 32'h0000_0100, 8'h01, 2'b10, 2'b00, 1'b1, 2);  // same, BE, turnaround
        run_xfer(0, 32'h0000_1232, 8'h04, 2'b00, 2'b10, 1'b0, 1);  // byte on bus32 LE
        run_xfer(0, 32'h0000_1232, 8'h04, 2'b00, 2'b10, 1'b1, 1);  // byte on bus32 BE
        run_xfer(0, 32'h0000_0056, 8'h20, 2'b01, 2'b01, 1'b0, 1);  // half on bus16
        run_xfer(1, 32'h0000_0346, 8'h80, 2'b01, 2'b00, 1'b0, 3);  // half on bus8, turnaround
    endtask

    task automatic test_reject();
        logic [7:0] bad_cs [2];
        logic [1:0] bad_xs [2];
        bad_cs[0] = 8'h03; bad_xs[0] = 2'b00;
        bad_cs[1] = 8'h10; bad_xs[1] = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            req_addr = $urandom; req_cs = bad_cs[i]; xs = bad_xs[i]; bs = 2'b00; be = 1'b0;
            req_valid[0] = 1'b1;
            @(negedge clk);
            req_valid[0] = 1'b0;
            checks += 6;
            if (o_err[0] !== 1'b1)           begin errors++; $display("FAIL rej_err case=%0d got=%b exp=1", i, o_err[0]); end
            if (o_ready[0] !== 1'b1)         begin errors++; $display("FAIL rej_ready case=%0d got=%b exp=1", i, o_ready[0]); end
            if (o_busy[0] !== 1'b0)          begin errors++; $display("FAIL rej_busy case=%0d got=%b exp=0", i, o_busy[0]); end
            if (o_ncs[0] !== 8'hFF)          begin errors++; $display("FAIL rej_ncs case=%0d got=%b exp=11111111", i, o_ncs[0]); end
            if (o_nbe[0] !== 4'hF)           begin errors++; $display("FAIL rej_nbe case=%0d got=%b exp=1111", i, o_nbe[0]); end
            if (o_addr[0] !== last_addr[0])  begin errors++; $display("FAIL rej_addr case=%0d got=%h exp=%h", i, o_addr[0], last_addr[0]); end
            @(negedge clk);
            checks += 2;
            if (o_err[0] !== 1'b0)           begin errors++; $display("FAIL rej_err_pulse case=%0d got=%b exp=0", i, o_err[0]); end
            if (o_addr[0] !== last_addr[0])  begin errors++; $display("FAIL rej_addr_later case=%0d got=%h exp=%h", i, o_addr[0], last_addr[0]); end
        end
    endtask

    task automatic test_abort();
        req_addr = 32'h200; req_cs = 8'h01; xs = 2'b10; bs = 2'b00; be = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        beat_done[0] = 1'b1;
        @(negedge clk);
        beat_done[0] = 1'b0;
        checks += 2;
        if (o_addr[0] !== 32'h202) begin errors++; $display("FAIL abort_pre_addr got=%h exp=00000202", o_addr[0]); end
        if (o_bidx[0] !== 2'd1)    begin errors++; $display("FAIL abort_pre_idx got=%0d exp=1", o_bidx[0]); end
        abort_i[0] = 1'b1; beat_done[0] = 1'b1;
        @(negedge clk);
        abort_i[0] = 1'b0; beat_done[0] = 1'b0;
        checks += 5;
        if (o_busy[0] !== 1'b0)  begin errors++; $display("FAIL abort_busy got=%b exp=0", o_busy[0]); end
        if (o_ncs[0] !== 8'hFF)  begin errors++; $display("FAIL abort_ncs got=%b exp=11111111", o_ncs[0]); end
        if (o_nbe[0] !== 4'hF)   begin errors++; $display("FAIL abort_nbe got=%b exp=1111", o_nbe[0]); end
        if (o_done[0] !== 1'b0)  begin errors++; $display("FAIL abort_done got=%b exp=0", o_done[0]); end
        if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", o_ready[0]); end
        run_xfer(0, 32'h0000_0410, 8'h02, 2'b01, 2'b00, 1'b1, 1);
        // abort wins over a simultaneous request in IDLE
        req_addr = 32'h500; req_cs = 8'h01; xs = 2'b00; bs = 2'b00; be = 1'b0;
        req_valid[0] = 1'b1; abort_i[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0; abort_i[0] = 1'b0;
        checks += 2;
        if (o_busy[0] !== 1'b0) begin errors++; $display("FAIL abort_vs_req_busy got=%b exp=0", o_busy[0]); end
        if (o_ncs[0] !== 8'hFF) begin errors++; $display("FAIL abort_vs_req_ncs got=%b exp=11111111", o_ncs[0]); end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 1));
            run_xfer(sel, $urandom, 8'b1 << $urandom_range(0, 7), 2'($urandom_range(0, 2)),
                     2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_addr = 32'h0000_0700; req_cs = 8'h08; xs = 2'b10; bs = 2'b01; be = 1'b0;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        checks++;
        if (o_busy[1] !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got=%b exp=1", o_busy[1]); end
        #2 rst_n = 1'b0;
        #1;
        checks += 6;
        if (o_addr[1] !== 32'h0) begin errors++; $display("FAIL arst_addr got=%h exp=0", o_addr[1]); end
        if (o_ncs[1] !== 8'hFF)  begin errors++; $display("FAIL arst_ncs got=%b exp=11111111", o_ncs[1]); end
        if (o_nbe[1] !== 4'hF)   begin errors++; $display("FAIL arst_nbe got=%b exp=1111", o_nbe[1]); end
        if (o_busy[1] !== 1'b0)  begin errors++; $display("FAIL arst_busy got=%b exp=0", o_busy[1]); end
        if (o_last[1] !== 1'b0)  begin errors++; $display("FAIL arst_last got=%b exp=0", o_last[1]); end
        if (o_ready[1] !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", o_ready[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; beat_done[s] = 1'b0; abort_i[s] = 1'b0; last_addr[s] = 32'h0;
        end
        req_addr = 32'h0; req_cs = 8'h0; xs = 2'b00; bs = 2'b00; be = 1'b0;
        test_reset();
        test_plan_directed();
        test_reject();
        test_abort();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smc_addr_seq16.md
# smc_addr_seq16

Parametrised address, chip-select and byte-enable sequencer for the SMC lite memory controller. It accepts one AHB-side transfer request and counts the external beats itself, instead of taking an access counter from outside. It drives registered EMI address, one-hot active-low chip selects and byte enables for each beat, and supports selectable endianness per request. An optional chip-select turnaround gap can be inserted between beats. It sits between the AHB slave interface and the SMC timing state machine, which reports beat completion.

## Interface
- ADDR_W, 32, EMI address width (>=4)
- NUM_CS, 8, number of chip selects (1..8)
- TURN_CYC, 0, cycles with n_cs/n_be high between beats of one transfer (0..3)

- sys_clk16  in  1  system clock
- n_sys_reset16  in  1  asynchronous, active-low reset
- req_valid  in  1  transfer request
- req_ready  out  1  high in IDLE; a request is accepted when req_valid&req_ready
- req_addr  in  ADDR_W  byte address
- req_cs  in  NUM_CS  one-hot bank select
- req_xfer_size  in  2  transfer size (XSIZ_8/16/32)
- req_bus_size  in  2  bank bus width (BSIZ_8/16/32)
- req_big_endian  in  1  1 = big-endian lane/beat order
- beat_done  in  1  current beat complete (from timing FSM)
- abort  in  1  synchronous cancel
- smc_addr  out  ADDR_W  registered EMI address
- smc_n_cs  out  NUM_CS  registered chip selects, active low
- smc_n_be  out  4  registered byte enables, active low
- beat_idx  out  2  index of current beat
- last_beat  out  1  current beat is final
- busy  out  1  state != IDLE
- xfer_done  out  1  one-cycle pulse, transfer completed
- xfer_err  out  1  one-cycle pulse, request rejected

## Operation
- Size encodings: 8=2'b00, 16=2'b01, 32=2'b10; 2'b11 is invalid.
- Beats N = max(1, xfer_bytes/bus_bytes), giving 1, 2 or 4. Beat index k runs 0..N-1.
- Reject a request with xfer_err if either size is 2'b11 or req_cs is not exactly one-hot. A rejected request leaves the block in IDLE and produces no outputs.
- Upper address bits smc_addr[ADDR_W-1:2] = req_addr[ADDR_W-1:2], captured at acceptance.
- Low address bits smc_addr[1:0]:
  - xfer8: req_addr[1:0].
  - Otherwise: aligned base plus offset. The base is {a1,0} for xfer16 and 00 for xfer32. The offset is (N-1-k)*bus_bytes for little-endian and k*bus_bytes for big-endian.
- Byte enables, bus8: always 1110.
- Byte enables, bus16:
  - xfer8: lane = a0 for LE, !a0 for BE.
  - otherwise: 1100.
- Byte enables, bus32:
  - xfer8: lane = a[1:0] for LE, 3-a[1:0] for BE.
  - xfer16: upper half iff a1 for LE, iff !a1 for BE.
  - xfer32: 0000.
- FSM states and transitions:
  - IDLE: on a valid request, go to ACCESS with k=0.
  - ACCESS: on beat_done with k<N-1, increment k and go to TURN (if TURN_CYC>0) or stay in ACCESS. On beat_done with k=N-1, go to IDLE.
  - TURN: count TURN_CYC cycles, then go to ACCESS.
- smc_n_cs: selected bit low only in ACCESS, all others high.
- smc_n_be: decoded value in ACCESS, 4'hF elsewhere.
- Address update timing: smc_addr updates to beat k+1 on leaving ACCESS, so it is stable throughout TURN. smc_addr holds its value in IDLE.

## Timing
- Reset values: smc_addr 0, smc_n_cs all 1, smc_n_be 4'hF, beat_idx 0, last_beat 0, busy 0, xfer_done 0, xfer_err 0, req_ready 1.
- Latency: request accepted at edge t; beat 0 outputs are valid from t+1.
- With TURN_CYC=0, smc_n_cs stays low across beats and only address/n_be change.
- xfer_done pulses in the cycle after the final beat_done, together with return to IDLE. A new request may be accepted in that same cycle.
- xfer_err pulses the cycle after a rejected request.
- beat_done outside ACCESS is ignored.
- abort forces IDLE at the next edge from any state. Outputs return to idle values and no xfer_done is produced.
- abort beats beat_done and req_valid in the same cycle.
- Asynchronous reset mid-transfer returns all outputs to their reset values immediately.

## Structure
- Package smc_lite16_pkg holds:
  - XSIZ_*/BSIZ_* encodings;
  - FSM state enum {IDLE, ACCESS, TURN};
  - function num_beats(xfer, bus).
- Sub-module smc_be_dec16: combinational byte-enable/lane decoder (xfer, bus, big_endian, addr[1:0]) -> n_be[3:0]. It is instantiated once.

## Test plan
- XSIZ_32/BSIZ_8, LE, addr 0x100, beat_done each 2 cycles: smc_addr 0x103, 0x102, 0x101, 0x100; n_be 1110; n_cs[0] low continuously; one xfer_done.
- Same transfer with BE, TURN_CYC=2: addresses 0x100..0x103; n_cs high for exactly 2 cycles between beats, with the next address stable during the gap.
- XSIZ_8/BSIZ_32, addr 0x…2: LE gives n_be 1011; BE gives 1101; single beat; last_beat=1.
- XSIZ_16/BSIZ_16, addr 0x…6, cs=8'b0010_0000: addr 0x…6, n_be 1100, smc_n_cs=8'b1101_1111.
- req_cs=8'b0000_0011, or xfer size 2'b11: xfer_err pulse, req_ready stays 1, outputs never change.
- abort during beat 1 of a 4-beat transfer: next cycle busy 0, n_cs all 1, n_be F, no xfer_done. A request in the following cycle is accepted.
